keypad_scanner: RTL and testbench

//  4x4 matrix keypad front end. Drives active-low column strobes, synchronises and

---
 rtl/keypad_pkg.sv | 38 +++
 rtl/sync_2ff.sv | 28 ++
 rtl/keypad_scanner.sv | 133 +++++++++++++
 tb/tb_keypad_scanner.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and key index constants for the 4x4 keypad front end.
// Key index is row*4 + col; the calculator input stage decodes these values.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      VALID    = 2'd2,
      RELEASE  = 2'd3
   } kp_state_e;

   localparam logic [3:0] KEY_1    = 4'd0;
   localparam logic [3:0] KEY_2    = 4'd1;
   localparam logic [3:0] KEY_3    = 4'd2;
   localparam logic [3:0] KEY_ADD  = 4'd3;
   localparam logic [3:0] KEY_4    = 4'd4;
   localparam logic [3:0] KEY_5    = 4'd5;
   localparam logic [3:0] KEY_6    = 4'd6;
   localparam logic [3:0] KEY_SUB  = 4'd7;
   localparam logic [3:0] KEY_7    = 4'd8;
   localparam logic [3:0] KEY_8    = 4'd9;
   localparam logic [3:0] KEY_9    = 4'd10;
   localparam logic [3:0] KEY_MULT = 4'd11;
   localparam logic [3:0] KEY_EQ   = 4'd12;
   localparam logic [3:0] KEY_0    = 4'd13;
   localparam logic [3:0] KEY_NEG  = 4'd15;

   // Index of the lowest active-low bit; only meaningful when some bit is low.
   function automatic logic [1:0] lowest_low(input logic [3:0] rows);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (!rows[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs, with a selectable reset value
// so idle-high buses come out of reset looking idle.
module sync_2ff #(
   parameter int               WIDTH   = 4,
   parameter logic [WIDTH-1:0] RST_VAL = '1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: one-cold column strobe, synchronised row returns, press and
// release debounce, and a valid/ack handshake delivering one code per press.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV        = 4,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic       clk,
   input  logic       nRST,
   input  logic [3:0] RowIn,
   output logic [3:0] ColOut,
   output logic       key_valid,
   output logic [3:0] key_code,
   input  logic       key_ack,
   output logic       key_pressed
);

   localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [3:0]       row_s;
   logic             row_any;
   logic [1:0]       row_low;

   kp_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       col_q, col_d;
   logic [1:0]       row_q, row_d;
   logic             valid_q, valid_d;
   logic [3:0]       code_q, code_d;

   sync_2ff #(.WIDTH(4), .RST_VAL(4'b1111)) u_row_sync (
      .clk   (clk),
      .rst_n (nRST),
      .d     (RowIn),
      .q     (row_s)
   );

   assign row_any = ~&row_s;
   assign row_low = lowest_low(row_s);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      col_d   = col_q;
      row_d   = row_q;
      valid_d = valid_q;
      code_d  = code_q;
      case (state_q)
         SCAN: begin
            if (cnt_q == DWELL_LAST) begin
               cnt_d = '0;
               if (row_any) begin
                  row_d   = row_low;
                  state_d = DEBOUNCE;
               end else begin
                  col_d = col_q + 2'd1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DEBOUNCE: begin
            // Stable means the winning (lowest) row is unchanged, so a second row
            // held in the same column does not defeat the press.
            if (row_any && (row_low == row_q)) begin
               if (cnt_q == DEB_LAST) begin
                  state_d = VALID;
                  cnt_d   = '0;
                  valid_d = 1'b1;
                  code_d  = {row_q, col_q};
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else begin
               state_d = SCAN;
               cnt_d   = '0;
               col_d   = col_q + 2'd1;
            end
         end
         VALID: begin
            if (key_ack) begin
               valid_d = 1'b0;
               state_d = RELEASE;
               cnt_d   = '0;
            end
         end
         RELEASE: begin
            if (row_any) begin
               cnt_d = '0;
            end else if (cnt_q == DEB_LAST) begin
               state_d = SCAN;
               cnt_d   = '0;
               col_d   = col_q + 2'd1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = SCAN;
            cnt_d   = '0;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         state_q <= SCAN;
         cnt_q   <= '0;
         col_q   <= 2'd0;
         row_q   <= 2'd0;
         valid_q <= 1'b0;
         code_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         col_q   <= col_d;
         row_q   <= row_d;
         valid_q <= valid_d;
         code_q  <= code_d;
      end
   end

   assign ColOut      = ~(4'b0001 << col_q);
   assign key_valid   = valid_q;
   assign key_code    = code_q;
   assign key_pressed = row_any;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad matrix model drives RowIn from ColOut; expected
// codes are queued at press time and popped when key_valid is observed.
module tb_keypad_scanner;
   import keypad_pkg::*;

   localparam int SCAN_DIV = 4;
   localparam int DEB      = 16;
   localparam int BUDGET   = 60;

   logic       clk = 1'b0;
   logic       nRST = 1'b0;
   logic [3:0] RowIn;
   logic [3:0] ColOut;
   logic       key_valid;
   logic [3:0] key_code;
   logic       key_ack = 1'b0;
   logic       key_pressed;

   logic [15:0] keys = '0;
   logic [3:0]  exp_q[$];
   int checks = 0;
   int failures = 0;

   keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DEB)) dut (
      .clk         (clk),
      .nRST        (nRST),
      .RowIn       (RowIn),
      .ColOut      (ColOut),
      .key_valid   (key_valid),
      .key_code    (key_code),
      .key_ack     (key_ack),
      .key_pressed (key_pressed)
   );

   always #5 clk = ~clk;

   always_comb begin
      RowIn = 4'b1111;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && !ColOut[c]) RowIn[r] = 1'b0;
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic wait_valid(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < BUDGET && !seen; i++) begin
         step();
         if (key_valid) seen = 1'b1;
      end
   endtask

   task automatic test_reset();
      logic [3:0] exp_col;
      nRST = 1'b0;
      repeat (3) step();
      checks++;
      if (ColOut !== 4'b1110) begin failures++; $display("FAIL reset_col got=%b exp=1110", ColOut); end
      checks++;
      if (key_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", key_valid); end
      checks++;
      if (key_code !== 4'd0) begin failures++; $display("FAIL reset_code got=%0d exp=0", key_code); end
      checks++;
      if (key_pressed !== 1'b0) begin failures++; $display("FAIL reset_pressed got=%b exp=0", key_pressed); end
      nRST = 1'b1;
      step();
      for (int k = 0; k <= 4; k++) begin
         exp_col = ~(4'b0001 << (k % 4));
         checks++;
         if (ColOut !== exp_col) begin
            failures++; $display("FAIL scan_walk k=%0d got=%b exp=%b", k, ColOut, exp_col);
         end
         if (k < 4) repeat (SCAN_DIV) step();
      end
   endtask

   task automatic test_key6();
      bit seen;
      bit dup;
      int changes;
      logic [3:0] last_col;
      logic [3:0] exp;
      exp_q.push_back(KEY_6);
      keys[KEY_6] = 1'b1;
      wait_valid(seen);
      checks++;
      if (!seen) begin failures++; $display("FAIL key6_valid timeout got=0 exp=1"); end
      exp = exp_q.pop_front();
      checks++;
      if (key_code !== exp) begin failures++; $display("FAIL key6_code got=%0d exp=%0d", key_code, exp); end
      key_ack = 1'b1;
      step();
      key_ack = 1'b0;
      checks++;
      if (key_valid !== 1'b0) begin failures++; $display("FAIL key6_ack_drop got=%b exp=0", key_valid); end
      dup = 1'b0;
      repeat (50) begin step(); if (key_valid) dup = 1'b1; end
      checks++;
      if (dup) begin failures++; $display("FAIL key6_held_dup got=1 exp=0"); end
      keys = '0;
      changes = 0;
      last_col = ColOut;
      repeat (80) begin
         step();
         if (key_valid) dup = 1'b1;
         if (ColOut !== last_col) changes++;
         last_col = ColOut;
      end
      checks++;
      if (changes < 4) begin failures++; $display("FAIL key6_rescan changes got=%0d exp>=4", changes); end
      checks++;
      if (dup) begin failures++; $display("FAIL key6_release_dup got=1 exp=0"); end
   endtask

   task automatic test_bounce();
      bit hit;
      int changes;
      logic [3:0] last_col;
      for (int i = 0; i < 40 && ColOut !== 4'b1110; i++) step();
      keys[KEY_1] = 1'b1;
      hit = 1'b0;
      repeat (10) begin step(); if (key_valid) hit = 1'b1; end
      keys = '0;
      changes = 0;
      last_col = ColOut;
      repeat (100) begin
         step();
         if (key_valid) hit = 1'b1;
         if (ColOut !== last_col) changes++;
         last_col = ColOut;
      end
      checks++;
      if (hit) begin failures++; $display("FAIL bounce_valid got=1 exp=0"); end
      checks++;
      if (changes < 8) begin failures++; $display("FAIL bounce_scan changes got=%0d exp>=8", changes); end
   endtask

   task automatic test_no_ack();
      bit seen;
      bit bad;
      logic [3:0] exp;
      exp_q.push_back(KEY_EQ);
      keys[KEY_EQ] = 1'b1;
      wait_valid(seen);
      checks++;
      if (!seen) begin failures++; $display("FAIL noack_valid timeout got=0 exp=1"); end
      bad = 1'b0;
      repeat (200) begin
         step();
         if (key_valid !== 1'b1 || key_code !== KEY_EQ) bad = 1'b1;
      end
      checks++;
      if (bad) begin failures++; $display("FAIL noack_hold valid=%b code=%0d exp=1/12", key_valid, key_code); end
      keys = '0;
      repeat (40) step();
      exp = exp_q.pop_front();
      checks++;
      if (key_valid !== 1'b1 || key_code !== exp) begin
         failures++; $display("FAIL noack_after_release valid=%b code=%0d exp=1/%0d", key_valid, key_code, exp);
      end
      key_ack = 1'b1;
      step();
      key_ack = 1'b0;
      bad = key_valid;
      repeat (100) begin step(); if (key_valid) bad = 1'b1; end
      checks++;
      if (bad) begin failures++; $display("FAIL noack_single got=extra exp=one"); end
      checks++;
      if (exp_q.size() != 0) begin failures++; $display("FAIL noack_queue got=%0d exp=0", exp_q.size()); end
   endtask

   task automatic test_two_rows();
      bit seen;
      logic [3:0] exp;
      exp_q.push_back(KEY_4);
      keys[KEY_4] = 1'b1;
      keys[KEY_7] = 1'b1;
      wait_valid(seen);
      checks++;
      if (!seen) begin failures++; $display("FAIL tworow_valid timeout got=0 exp=1"); end
      exp = exp_q.pop_front();
      checks++;
      if (key_code !== exp) begin failures++; $display("FAIL tworow_code got=%0d exp=%0d", key_code, exp); end
      key_ack = 1'b1;
      step();
      key_ack = 1'b0;
      keys = '0;
      repeat (40) step();
   endtask

   task automatic test_reset_mid();
      bit seen;
      bit dup;
      logic [3:0] exp;
      exp_q.push_back(KEY_5);
      keys[KEY_5] = 1'b1;
      wait_valid(seen);
      checks++;
      if (!seen) begin failures++; $display("FAIL rstmid_valid timeout got=0 exp=1"); end
      exp = exp_q.pop_front();
      checks++;
      if (key_code !== exp) begin failures++; $display("FAIL rstmid_code got=%0d exp=%0d", key_code, exp); end
      nRST = 1'b0;
      #1;
      checks++;
      if (key_valid !== 1'b0 || ColOut !== 4'b1110) begin
         failures++; $display("FAIL rstmid_async valid=%b col=%b exp=0/1110", key_valid, ColOut);
      end
      repeat (3) step();
      exp_q.push_back(KEY_5);
      nRST = 1'b1;
      wait_valid(seen);
      checks++;
      if (!seen) begin failures++; $display("FAIL rstmid_redetect timeout got=0 exp=1"); end
      exp = exp_q.pop_front();
      checks++;
      if (key_code !== exp) begin failures++; $display("FAIL rstmid_recode got=%0d exp=%0d", key_code, exp); end
      key_ack = 1'b1;
      step();
      key_ack = 1'b0;
      dup = key_valid;
      repeat (40) begin step(); if (key_valid) dup = 1'b1; end
      keys = '0;
      repeat (60) begin step(); if (key_valid) dup = 1'b1; end
      checks++;
      if (dup) begin failures++; $display("FAIL rstmid_once got=extra exp=one"); end
      checks++;
      if (exp_q.size() != 0) begin failures++; $display("FAIL rstmid_queue got=%0d exp=0", exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_key6();
      test_bounce();
      test_no_ack();
      test_two_rows();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
